hwt_seq_trigger: RTL and testbench

Sequential trigger stage that sits directly upstream of the payload point of the combinational A/B/C/D → Y logic. It samples the same four 1-bit inputs every clock and tracks progress through a programmed four-step input sequence. On a complete match it asserts a trigger for a fixed window and, when compiled in, inverts the logic stage's Y on its way downstream. Its status outputs expose arming progress and fire history to the bench.

---
 rtl/hwt_seq_trigger.sv | 109 ++++++++++
 tb/tb_hwt_seq_trigger.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hwt_seq_trigger.sv
// Sequence trigger: watches {A,B,C,D} for the programmed P0..P3 run and holds trig
// for HOLD_CYCLES clocks. Define HWT_PAYLOAD_EN to invert Y while trig is high.
module hwt_seq_trigger #(
   parameter logic [3:0]  P0          = 4'b1000,
   parameter logic [3:0]  P1          = 4'b1100,
   parameter logic [3:0]  P2          = 4'b1110,
   parameter logic [3:0]  P3          = 4'b1111,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   input  logic       Y_in,
   output logic       Y_out,
   output logic       trig,
   output logic [1:0] armed,
   output logic [7:0] fire_cnt,
   output logic [2:0] state_dbg
);

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      FIRE = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic [7:0] fire_nxt;
   logic [3:0] nib;

   assign nib = {A, B, C, D};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         fire_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         fire_cnt <= fire_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      fire_nxt  = fire_cnt;
      case (state)
         IDLE: if (nib == P0) state_nxt = S1;
         S1: begin
            if (nib == P1)      state_nxt = S2;
            else if (nib == P0) state_nxt = S1;
            else                state_nxt = IDLE;
         end
         S2: begin
            if (nib == P2)      state_nxt = S3;
            else if (nib == P0) state_nxt = S1;
            else                state_nxt = IDLE;
         end
         S3: begin
            if (nib == P3) begin
               state_nxt = FIRE;
               hold_nxt  = HOLD_LOAD;
               if (fire_cnt != 8'hFF) fire_nxt = fire_cnt + 8'd1;
            end else if (nib == P0) begin
               state_nxt = S1;
            end else begin
               state_nxt = IDLE;
            end
         end
         FIRE: begin
            // Inputs are ignored here; detection resumes only from IDLE.
            if (hold_cnt == 8'd0) state_nxt = IDLE;
            else                  hold_nxt  = hold_cnt - 8'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // trig and armed decode only the state register, never the live inputs.
   always_comb begin
      armed = 2'd0;
      case (state)
         S1:      armed = 2'd1;
         S2:      armed = 2'd2;
         S3:      armed = 2'd3;
         default: armed = 2'd0;
      endcase
   end

   assign trig      = (state == FIRE);
   assign state_dbg = state;

`ifdef HWT_PAYLOAD_EN
   assign Y_out = Y_in ^ trig;
`else
   assign Y_out = Y_in;
`endif

endmodule

// File: tb/tb_hwt_seq_trigger.sv
// Directed bench for hwt_seq_trigger: a HOLD_CYCLES=8 instance for the main checks
// and a HOLD_CYCLES=1 instance for back-to-back fires and fire_cnt saturation.
module tb_hwt_seq_trigger;

   logic       clk;
   logic       rst, A, B, C, D, Y_in;
   logic       Y_out, trig;
   logic [1:0] armed;
   logic [7:0] fire_cnt;
   logic [2:0] state_dbg;

   logic       rst1, A1, B1, C1, D1, Y_in1;
   logic       Y_out1, trig1;
   logic [1:0] armed1;
   logic [7:0] fire_cnt1;
   logic [2:0] state_dbg1;

   int tests = 0;
   int fails = 0;

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   hwt_seq_trigger #(.HOLD_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .Y_in(Y_in),
      .Y_out(Y_out), .trig(trig), .armed(armed), .fire_cnt(fire_cnt),
      .state_dbg(state_dbg)
   );

   hwt_seq_trigger #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .A(A1), .B(B1), .C(C1), .D(D1), .Y_in(Y_in1),
      .Y_out(Y_out1), .trig(trig1), .armed(armed1), .fire_cnt(fire_cnt1),
      .state_dbg(state_dbg1)
   );

   function automatic logic exp_y(input logic y, input logic t);
`ifdef HWT_PAYLOAD_EN
      return y ^ t;
`else
      return y;
`endif
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
   task automatic apply(input logic [3:0] n);
      {A, B, C, D} = n;
      @(posedge clk);
      #1;
   endtask

   task automatic apply1(input logic [3:0] n);
      {A1, B1, C1, D1} = n;
      @(posedge clk);
      #1;
   endtask

   task automatic check_main(input string tag, input logic e_trig, input logic [1:0] e_armed,
                             input logic [7:0] e_cnt);
      check({tag, ".trig"}, {7'd0, trig}, {7'd0, e_trig});
      check({tag, ".armed"}, {6'd0, armed}, {6'd0, e_armed});
      check({tag, ".fire_cnt"}, fire_cnt, e_cnt);
      check({tag, ".y_out"}, {7'd0, Y_out}, {7'd0, exp_y(Y_in, e_trig)});
   endtask

   logic [3:0] window_nib [7];
   int         exp_sat;

   initial begin
      window_nib[0] = 4'b1000; window_nib[1] = 4'b1100; window_nib[2] = 4'b1110;
      window_nib[3] = 4'b1111; window_nib[4] = 4'b1010; window_nib[5] = 4'b0101;
      window_nib[6] = 4'b1000;

      rst = 1'b1; {A, B, C, D} = 4'b0000; Y_in = 1'b1;
      rst1 = 1'b1; {A1, B1, C1, D1} = 4'b0000; Y_in1 = 1'b1;
      @(posedge clk); #1;
      apply(4'b0000);
      check_main("reset", 1'b0, 2'd0, 8'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         Y_in = i[0];
         apply(4'b0000);
      end
      check_main("idle_zero", 1'b0, 2'd0, 8'd0);

      // First fire; arbitrary patterns, including the sequence itself, during the window
      Y_in = 1'b1;
      apply(4'b1000); check_main("seq1.s1", 1'b0, 2'd1, 8'd0);
      apply(4'b1100); check_main("seq1.s2", 1'b0, 2'd2, 8'd0);
      apply(4'b1110); check_main("seq1.s3", 1'b0, 2'd3, 8'd0);
      apply(4'b1111); check_main("seq1.fire0", 1'b1, 2'd0, 8'd1);
      for (int i = 0; i < 7; i++) begin
         Y_in = (i % 3 != 0);
         apply(window_nib[i]);
         check_main($sformatf("seq1.win%0d", i + 1), 1'b1, 2'd0, 8'd1);
      end
      Y_in = 1'b1;
      apply(4'b1000); check_main("seq1.exit", 1'b0, 2'd0, 8'd1);

      // Second fire right after leaving FIRE
      apply(4'b1000); check_main("seq2.s1", 1'b0, 2'd1, 8'd1);
      apply(4'b1100); check_main("seq2.s2", 1'b0, 2'd2, 8'd1);
      apply(4'b1110); check_main("seq2.s3", 1'b0, 2'd3, 8'd1);
      apply(4'b1111); check_main("seq2.fire0", 1'b1, 2'd0, 8'd2);
      for (int i = 0; i < 7; i++) apply(4'b0000);
      check_main("seq2.win7", 1'b1, 2'd0, 8'd2);
      apply(4'b0000); check_main("seq2.exit", 1'b0, 2'd0, 8'd2);

      // Broken sequences
      apply(4'b1000); check_main("brk1.s1", 1'b0, 2'd1, 8'd2);
      apply(4'b1100); check_main("brk1.s2", 1'b0, 2'd2, 8'd2);
      apply(4'b1011); check_main("brk1.idle", 1'b0, 2'd0, 8'd2);
      apply(4'b1000); check_main("brk2.s1", 1'b0, 2'd1, 8'd2);
      apply(4'b1100); check_main("brk2.s2", 1'b0, 2'd2, 8'd2);
      apply(4'b1000); check_main("brk2.rearm", 1'b0, 2'd1, 8'd2);
      apply(4'b1100); check_main("rep.s2", 1'b0, 2'd2, 8'd2);
      apply(4'b1100); check_main("rep.restart", 1'b0, 2'd0, 8'd2);
      apply(4'b1111); check_main("brk.nofire", 1'b0, 2'd0, 8'd2);

      // Reset three clocks into a fire window
      apply(4'b1000); apply(4'b1100); apply(4'b1110);
      apply(4'b1111); check_main("seq3.fire0", 1'b1, 2'd0, 8'd3);
      apply(4'b0000); apply(4'b0000);
      check_main("seq3.fire2", 1'b1, 2'd0, 8'd3);
      rst = 1'b1;
      apply(4'b1111); check_main("rst_fire", 1'b0, 2'd0, 8'd0);
      rst = 1'b0;
      apply(4'b1000); check_main("post_rst.s1", 1'b0, 2'd1, 8'd0);

      // HOLD_CYCLES=1: 256 back-to-back sequences, one-clock pulses, saturation at 255
      apply1(4'b0000);
      rst1 = 1'b0;
      check("h1.reset.cnt", fire_cnt1, 8'd0);
      for (int k = 1; k <= 256; k++) begin
         Y_in1 = k[0];
         apply1(4'b1000); apply1(4'b1100); apply1(4'b1110);
         check("h1.armed3", {6'd0, armed1}, 8'd3);
         apply1(4'b1111);
         exp_sat = (k > 255) ? 255 : k;
         check($sformatf("h1.trig_on%0d", k), {7'd0, trig1}, 8'd1);
         check($sformatf("h1.cnt%0d", k), fire_cnt1, 8'(exp_sat));
         check("h1.y_out", {7'd0, Y_out1}, {7'd0, exp_y(Y_in1, 1'b1)});
         apply1(4'b1000);
         check($sformatf("h1.trig_off%0d", k), {7'd0, trig1}, 8'd0);
         check("h1.armed_exit", {6'd0, armed1}, 8'd0);
      end
      check("h1.sat_final", fire_cnt1, 8'd255);

      // final report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
